// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state encodings and default widths for mem_arbiter.
package mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CPU  = 3'd1,
    LOAD = 3'd2,
    VRD  = 3'd3,
    VCMP = 3'd4
  } state_e;
endpackage

// File: rtl/arb_ptr.sv
// arb_ptr: loader write pointer with sticky wrap flag (pointer and flag clear independently).
module arb_ptr import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wrap_clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              wrap_o
);
  logic [ADDR_W-1:0] ptr_q;
  logic              wrap_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= clr_i ? '0 : inc_i ? ptr_q + 1'b1 : ptr_q;
      wrap_q <= wrap_clr_i ? 1'b0 : wrap_q | (inc_i & (&ptr_q));
    end
  end
  assign ptr_o  = ptr_q;
  assign wrap_o = wrap_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between a CPU and a priority program loader; ARB_VERIFY_EN adds read-back verify.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_hold,
  input  logic              ld_req,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_wrap,
  output logic              ld_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_re,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q, done_q, start, accept, fin, inc;
  assign start    = state_q == IDLE && ld_req;
  assign accept   = state_q == LOAD && ld_valid;
  assign cpu_hold = state_q == LOAD || state_q == VRD || state_q == VCMP;
  assign fin      = cpu_hold && state_d == IDLE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ld_req ? LOAD : cpu_req ? CPU : IDLE;
      CPU:     state_d = IDLE;
`ifdef ARB_VERIFY_EN
      LOAD:    state_d = accept ? VRD : ld_req ? LOAD : IDLE;
      VRD:     state_d = VCMP;
      VCMP:    state_d = ld_req ? LOAD : IDLE;
`else
      LOAD:    state_d = ld_req ? LOAD : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= cpu_gnt && !cpu_we;
      rdata_q  <= rvalid_q ? ram_rdata : rdata_q;
      done_q   <= fin;
    end
  end
  // read data is presented as it leaves the RAM and held in rdata_q afterwards
  assign cpu_rdata  = rvalid_q ? ram_rdata : rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_gnt    = state_q == CPU;
  assign ld_ready   = state_q == LOAD;
  assign ld_done    = done_q;
  assign ram_we     = cpu_gnt ? cpu_we : accept;
  assign ram_re     = cpu_gnt ? !cpu_we : state_q == VRD;
  assign ram_addr   = cpu_gnt ? cpu_addr : cpu_hold ? ptr : '0;
  assign ram_wdata  = cpu_gnt ? cpu_wdata : accept ? ld_data : '0;
`ifdef ARB_VERIFY_EN
  logic [DATA_W-1:0] byte_q;
  logic              err_q;
  // the pointer advances only once the verify of its byte completes
  assign inc = state_q == VCMP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q <= '0;
      err_q  <= 1'b0;
    end else begin
      byte_q <= accept ? ld_data : byte_q;
      err_q  <= start ? 1'b0 : err_q | (state_q == VCMP && ram_rdata != byte_q);
    end
  end
  assign ld_err = err_q;
`else
  assign inc    = accept;
  assign ld_err = 1'b0;
`endif
  arb_ptr #(.ADDR_W(ADDR_W)) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start || fin),
    .wrap_clr_i (start),
    .inc_i      (inc),
    .ptr_o      (ptr),
    .wrap_o     (ld_wrap)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter against a RAM model and reference memory.
module tb_mem_arbiter;
  logic       clk, rst, cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_hold;
  logic [3:0] cpu_addr, ram_addr;
  logic [7:0] cpu_wdata, cpu_rdata, ld_data, ram_wdata, ram_rdata;
  logic       ld_req, ld_valid, ld_ready, ld_done, ld_wrap, ld_err, ram_we, ram_re, frc;
  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  int         wr_cnt = 0, checks = 0, errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cpu_hold(cpu_hold), .ld_req(ld_req), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_wrap(ld_wrap), .ld_err(ld_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // synchronous RAM; frc makes address 2 read back as 0xFF
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (ram_re) ram_rdata <= (frc && ram_addr == 4'd2) ? 8'hFF : mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [3:0] a, input logic [7:0] d);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    tick;
    chk("cpu_gnt", cpu_gnt, 1);
    chk("cpu_ram", {ram_we, ram_re, ram_addr}, {we, !we, a});
    cpu_req = 0;
    tick;
    chk("cpu_gnt_pulse", cpu_gnt, 0);
    chk("cpu_rvalid", cpu_rvalid, !we);
    if (we) ref_mem[a] = d;
    else chk("cpu_rdata", cpu_rdata, ref_mem[a]);
  endtask

  // mode 0: valid always, 1: every other cycle, 2: random; base<0 gives random data
  task automatic load(input int n, input int mode, input int base, input bit abort);
    int sent, cyc, w0;
    bit gs, ee, acc;
    logic [7:0] b;
    sent = 0; cyc = 0; w0 = wr_cnt; gs = 0; ee = 0;
    b = base < 0 ? 8'($urandom) : 8'(base);
    ld_req = 1;
    tick;
    chk("ld_hold", cpu_hold, 1);
    while (sent < n && cyc < 200) begin
      ld_valid = mode == 0 || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom_range(0, 1) == 1);
      ld_data = b;
      acc = ld_valid && ld_ready;
      tick;
      cyc++;
      gs |= cpu_gnt;
      if (acc) begin
        ref_mem[sent % 16] = b;
`ifdef ARB_VERIFY_EN
        if (frc && sent % 16 == 2 && b != 8'hFF) ee = 1;
`endif
        sent++;
        b = base < 0 ? 8'($urandom) : 8'(base + sent);
      end
    end
    chk("ld_sent", sent, n);
    ld_valid = 0;
    if (abort) begin
      rst = 1; ld_req = 0;
      #2;
      chk("arst_hold", cpu_hold, 0);
      chk("arst_ready", ld_ready, 0);
      chk("arst_ram", {ram_we, ram_re}, 0);
      chk("arst_err", ld_err, 0);
      chk("arst_wrap", ld_wrap, 0);
      chk("arst_ptr", dut.u_ptr.ptr_q, 0);
      rst = 0;
      tick;
      chk("arst_wr_cnt", wr_cnt - w0, n);
    end else begin
      ld_req = 0;
      cyc = 0;
      do begin
        tick;
        gs |= cpu_gnt;
        cyc++;
      end while (!ld_done && cyc < 8);
      chk("ld_done", ld_done, 1);
      chk("ld_hold_end", cpu_hold, 0);
      chk("ld_wrap", ld_wrap, n >= 16);
      chk("ld_err", ld_err, ee);
      chk("ld_wr_cnt", wr_cnt - w0, n);
      chk("ld_no_gnt", gs, 0);
      tick;
      chk("ld_done_pulse", ld_done, 0);
      chk("ld_err_hold", ld_err, ee);
    end
    for (int i = 0; i < 16; i++) chk("ld_mem", mem[i], ref_mem[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_valid = 0; ld_data = 0; frc = 0;
    #2;
    chk("rst_cpu", {cpu_gnt, cpu_rvalid, cpu_hold, cpu_rdata}, 0);
    chk("rst_ld", {ld_ready, ld_done, ld_wrap, ld_err}, 0);
    chk("rst_ram", {ram_we, ram_re, ram_addr, ram_wdata}, 0);
    tick; tick;
    rst = 0;
    tick;
    for (int i = 0; i < 16; i++) cpu_access(1, i[3:0], 8'($urandom));
    cpu_access(1, 4'd3, 8'h2A);
    cpu_access(0, 4'd3, 8'h00);
    chk("rd3_value", cpu_rdata, 8'h2A);
    tick;
    chk("rd3_rvalid_pulse", cpu_rvalid, 0);
    chk("rd3_rdata_hold", cpu_rdata, 8'h2A);
    load(16, 0, 8'h10, 0);
    chk("seq_last", mem[15], 8'h1F);
    rst = 1;
    #2;
    chk("rst2_wrap", ld_wrap, 0);
    chk("rst2_rdata", cpu_rdata, 0);
    rst = 0;
    tick;
    load(8, 1, -1, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd5;
    load(6, 2, -1, 0);
    chk("pend_gnt", cpu_gnt, 1);
    cpu_req = 0;
    tick;
    chk("pend_rvalid", cpu_rvalid, 1);
    chk("pend_rdata", cpu_rdata, ref_mem[5]);
    frc = 1;
    load(4, 0, 8'h53, 0);
`ifdef ARB_VERIFY_EN
    chk("verify_err", ld_err, 1);
`endif
    frc = 0;
    cpu_access(0, 4'd2, 8'h00);
    load(5, 0, -1, 1);
    for (int it = 0; it < 40; it++) begin
      int r;
      logic [3:0] a;
      r = $urandom_range(0, 9);
      a = 4'($urandom);
      if (r < 4) cpu_access(1, a, 8'($urandom));
      else if (r < 8) cpu_access(0, a, 8'h00);
      else begin
        if ($urandom_range(0, 1) == 1) begin
          cpu_req = 1; cpu_we = 0; cpu_addr = a;
        end
        load($urandom_range(1, 20), $urandom_range(0, 2), -1, 0);
        if (cpu_req) begin
          chk("rnd_pend_gnt", cpu_gnt, 1);
          cpu_req = 0;
          tick;
          chk("rnd_pend_rdata", cpu_rdata, ref_mem[a]);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
